// File: rtl/ttl74x469_counter.sv
// Purpose : WIDTH-bit synchronous up/down counter with parallel load, cascadable carry,
//           tri-state outputs and a sticky wrap flag, modelled on the 74x469 part.
// Latency : count and WRAP update one clk edge after inputs; CO_n is combinational.
// Backpressure: none; CI_n is the only enable, and CO_n feeds the CI_n of the next stage.
//
// Ports:
//   clk      rising-edge clock
//   CLR_n    asynchronous active-low clear (count, WRAP, preset register)
//   S[1:0]   00 hold, 01 load D, 10 count up, 11 count down
//   D        parallel load data (also preset register data)
//   CI_n     active-low carry in / count enable
//   OE_n     active-low output enable; Q is high-Z while high
//   PR_LD_n  active-low preset register load strobe
//   ARL      auto-reload enable
//   Q        count value (tri-state)
//   CO_n     active-low ripple carry out
//   WRAP     sticky flag, set by a terminal step, cleared by a load
//
// Optional feature: define TTL74X469_AUTORELOAD_EN to build the preset register and
// auto-reload path. Without it PR_LD_n and ARL are ignored and a terminal step wraps.
module ttl74x469_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             CLR_n,
  input  logic [1:0]       S,
  input  logic [WIDTH-1:0] D,
  input  logic             CI_n,
  input  logic             OE_n,
  input  logic             PR_LD_n,
  input  logic             ARL,
  output logic [WIDTH-1:0] Q,
  output logic             CO_n,
  output logic             WRAP
);

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_LOAD = 2'b01;
  localparam logic [1:0] MODE_UP   = 2'b10;
  localparam logic [1:0] MODE_DOWN = 2'b11;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q,  wrap_d;
  logic             terminal;
  logic [WIDTH-1:0] wrap_value;

  // Terminal step: counting is enabled and the count sits at the value it is about
  // to leave by wrapping. This is also what pulls CO_n low so cascaded stages step
  // on the same edge.
  always_comb begin
    terminal = 1'b0;
    if (!CI_n) begin
      if (S == MODE_UP   && count_q == {WIDTH{1'b1}}) terminal = 1'b1;
      if (S == MODE_DOWN && count_q == '0)            terminal = 1'b1;
    end
  end

`ifdef TTL74X469_AUTORELOAD_EN
  logic [WIDTH-1:0] preset_q, preset_d;

  // The reload uses preset_q, i.e. the value held before this edge, even when
  // PR_LD_n is loading a new preset on the same edge.
  always_comb begin
    preset_d = PR_LD_n ? preset_q : D;
  end

  always_comb begin
    wrap_value = (S == MODE_UP) ? '0 : {WIDTH{1'b1}};
    if (ARL) wrap_value = preset_q;
  end
`else
  // Inputs that only matter to the auto-reload build.
  logic unused_autoreload;
  assign unused_autoreload = PR_LD_n ^ ARL;

  always_comb begin
    wrap_value = (S == MODE_UP) ? '0 : {WIDTH{1'b1}};
  end
`endif

  always_comb begin
    count_d = count_q;
    wrap_d  = wrap_q;
    case (S)
      MODE_HOLD: count_d = count_q;
      MODE_LOAD: begin
        count_d = D;
        wrap_d  = 1'b0;
      end
      MODE_UP: begin
        if (!CI_n) count_d = terminal ? wrap_value : count_q + ONE;
      end
      MODE_DOWN: begin
        if (!CI_n) count_d = terminal ? wrap_value : count_q - ONE;
      end
      default: count_d = count_q;
    endcase
    if (terminal) wrap_d = 1'b1;
  end

  always_ff @(posedge clk or negedge CLR_n) begin
    if (!CLR_n) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

`ifdef TTL74X469_AUTORELOAD_EN
  always_ff @(posedge clk or negedge CLR_n) begin
    if (!CLR_n) preset_q <= '0;
    else        preset_q <= preset_d;
  end
`endif

  // OE_n only gates the drivers; it never reaches the count or the carry.
  assign Q    = OE_n ? {WIDTH{1'bz}} : count_q;
  assign CO_n = ~terminal;
  assign WRAP = wrap_q;

endmodule
